control_unit: RTL

//  Multicycle OTTER control FSM, directly upstream of the datapath.

---
 rtl/otter_ctrl_pkg.sv | 64 ++++++
 rtl/control_unit_if.sv | 43 ++++
 rtl/control_unit_alu_decoder.sv | 23 ++
 rtl/control_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/otter_ctrl_pkg.sv
// Shared encodings for the multicycle OTTER control unit: FSM states, opcodes,
// datapath mux-select enums, ALU operation constants and the control-word struct.
package otter_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic       {ADDR_PC, ADDR_ALU}                  addr_src_e;
  typedef enum logic [1:0] {REG_PC, REG_ALU, REG_MEM}           reg_src_e;
  typedef enum logic [1:0] {A_CURR_PC, A_OLD_PC, A_RS1, A_ZERO} alu_src_a_e;
  typedef enum logic [1:0] {B_RS2, B_IMMED, B_FOUR}             alu_src_b_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}  imm_src_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Shift-right is the only I-type op where inst[30] selects the operation.
  localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_we;
    logic       pc_update;
    logic       ir_write;
    addr_src_e  addr_src;
    reg_src_e   reg_src;
    logic       reg_write;
    imm_src_e   immed_src;
    alu_src_a_e alu_src_a;
    alu_src_b_e alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  return eq;
      F3_BNE:  return !eq;
      F3_BLT:  return lt;
      F3_BGE:  return !lt;
      F3_BLTU: return ltu;
      F3_BGEU: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath/memory bundle: decoded instruction fields, branch flags,
// memory handshake and every datapath strobe. OTTER_ILLEGAL_INST_EN adds illegal_inst.
interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       br_eq;
  logic       br_lt;
  logic       br_ltu;
  logic       mem_valid;
  logic       mem_rd;
  logic       mem_we;
  logic       pcUpdate;
  logic       irWrite;
  logic       addrSrc;
  logic [1:0] regSrc;
  logic       regWrite;
  logic [2:0] immedSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [3:0] aluOp;
`ifdef OTTER_ILLEGAL_INST_EN
  logic       illegal_inst;
`endif

  modport master (
    input  opcode, funct3, funct7_5, br_eq, br_lt, br_ltu, mem_valid,
`ifdef OTTER_ILLEGAL_INST_EN
    output illegal_inst,
`endif
    output mem_rd, mem_we, pcUpdate, irWrite, addrSrc, regSrc, regWrite,
           immedSrc, aluSrcA, aluSrcB, aluOp
  );

  modport slave (
    output opcode, funct3, funct7_5, br_eq, br_lt, br_ltu, mem_valid,
`ifdef OTTER_ILLEGAL_INST_EN
    input  illegal_inst,
`endif
    input  mem_rd, mem_we, pcUpdate, irWrite, addrSrc, regSrc, regWrite,
           immedSrc, aluSrcA, aluSrcB, aluOp
  );
endinterface

// File: rtl/control_unit_alu_decoder.sv
// ALU operation decode from the latched instruction fields; purely combinational.
module alu_decoder
  import otter_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_R: alu_op_o = {funct7_5_i, funct3_i};
      // For I-type, inst[30] is immediate data except in the shift-right encodings.
      OP_I: alu_op_o = (funct3_i == F3_SHIFT_RIGHT) ? {funct7_5_i, funct3_i}
                                                    : {1'b0, funct3_i};
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle OTTER control FSM: state register plus combinational strobe decode.
// Define OTTER_ILLEGAL_INST_EN to trap unknown opcodes in a HALT state with illegal_inst=1.
module control_unit
  import otter_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master bus
);

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic [3:0] dec_alu_op;

  alu_decoder u_alu_decoder (
    .opcode_i   (bus.opcode),
    .funct3_i   (bus.funct3),
    .funct7_5_i (bus.funct7_5),
    .alu_op_o   (dec_alu_op)
  );

  // NOTE: rst is sampled only on the clock edge (synchronous), and state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (bus.mem_valid) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:      state_d = EXEC_R;
          OP_I:      state_d = EXEC_I;
          OP_LOAD:   state_d = LOAD;
          OP_STORE:  state_d = STORE;
          OP_BRANCH: state_d = BRANCH;
          OP_JAL:    state_d = JAL;
          OP_JALR:   state_d = JALR;
          OP_LUI:    state_d = LUI;
          OP_AUIPC:  state_d = AUIPC;
`ifdef OTTER_ILLEGAL_INST_EN
          default:   state_d = HALT;
`else
          default:   state_d = FETCH;
`endif
        endcase
      end
      LOAD, STORE: if (bus.mem_valid) state_d = FETCH;
`ifdef OTTER_ILLEGAL_INST_EN
      HALT:    state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Strobes follow the current state and inputs; the IR still holds the previous
  // instruction during FETCH, so the ALU op is only taken from the decoder in EXEC_R/EXEC_I.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          ctrl.mem_rd   = 1'b1;
          ctrl.addr_src = ADDR_PC;
          if (bus.mem_valid) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_update = 1'b1;
            ctrl.alu_src_a = A_CURR_PC;
            ctrl.alu_src_b = B_FOUR;
            ctrl.alu_op    = ALU_ADD;
          end
        end
        EXEC_R: begin
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_RS2;
          ctrl.alu_op    = dec_alu_op;
          ctrl.reg_write = 1'b1;
          ctrl.reg_src   = REG_ALU;
        end
        EXEC_I: begin
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_I;
          ctrl.alu_op    = dec_alu_op;
          ctrl.reg_write = 1'b1;
          ctrl.reg_src   = REG_ALU;
        end
        LOAD: begin
          ctrl.mem_rd    = 1'b1;
          ctrl.addr_src  = ADDR_ALU;
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_I;
          ctrl.alu_op    = ALU_ADD;
          if (bus.mem_valid) begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_src   = REG_MEM;
          end
        end
        STORE: begin
          ctrl.mem_we    = 1'b1;
          ctrl.addr_src  = ADDR_ALU;
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_S;
          ctrl.alu_op    = ALU_ADD;
        end
        BRANCH: begin
          if (branch_taken(bus.funct3, bus.br_eq, bus.br_lt, bus.br_ltu)) begin
            ctrl.pc_update = 1'b1;
            ctrl.alu_src_a = A_OLD_PC;
            ctrl.alu_src_b = B_IMMED;
            ctrl.immed_src = IMM_B;
            ctrl.alu_op    = ALU_ADD;
          end
        end
        JAL: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_src   = REG_PC;
          ctrl.pc_update = 1'b1;
          ctrl.alu_src_a = A_OLD_PC;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_J;
          ctrl.alu_op    = ALU_ADD;
        end
        JALR: begin
          // rs1 is read before the edge, so rd==rs1 still jumps to the old rs1 value.
          ctrl.reg_write = 1'b1;
          ctrl.reg_src   = REG_PC;
          ctrl.pc_update = 1'b1;
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_I;
          ctrl.alu_op    = ALU_ADD;
        end
        LUI: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_src   = REG_ALU;
          ctrl.alu_src_a = A_ZERO;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_U;
          ctrl.alu_op    = ALU_ADD;
        end
        AUIPC: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_src   = REG_ALU;
          ctrl.alu_src_a = A_OLD_PC;
          ctrl.alu_src_b = B_IMMED;
          ctrl.immed_src = IMM_U;
          ctrl.alu_op    = ALU_ADD;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.mem_rd   = ctrl.mem_rd;
  assign bus.mem_we   = ctrl.mem_we;
  assign bus.pcUpdate = ctrl.pc_update;
  assign bus.irWrite  = ctrl.ir_write;
  assign bus.addrSrc  = ctrl.addr_src;
  assign bus.regSrc   = ctrl.reg_src;
  assign bus.regWrite = ctrl.reg_write;
  assign bus.immedSrc = ctrl.immed_src;
  assign bus.aluSrcA  = ctrl.alu_src_a;
  assign bus.aluSrcB  = ctrl.alu_src_b;
  assign bus.aluOp    = ctrl.alu_op;

`ifdef OTTER_ILLEGAL_INST_EN
  assign bus.illegal_inst = !rst && (state_q == HALT);
`endif

endmodule
